// File: rtl/dispatcher_if.sv
// Word type shared by the datapath and the FIFO interface the dispatcher pops from.
// dat_out is first-word-fall-through: the head entry is visible whenever empty is low.
package dispatcher_pkg;
    parameter int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
endpackage

interface FIFO_if #(
    parameter int BW = 2
);
    import dispatcher_pkg::*;

    logic  pop;
    word_t dat_out [0:BW-1];
    logic  empty;

    modport master (output pop, input dat_out, input empty);
    modport slave  (input pop, output dat_out, output empty);
endinterface

// File: rtl/dispatcher.sv
// Loads A (MxN) and B (NxK) from the input FIFO, then streams them skewed into the
// systolic array edges. Build option DISPATCH_BTRANS_EN: B arrives column-major.
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int M  = 2,
    parameter int N  = 2,
    parameter int K  = 2,
    parameter int BW = 2
) (
    input  logic          clk,
    input  logic          rst,
    FIFO_if.master        in_fifo_if,
    input  logic          start,
    output word_t         a_in [0:M-1],
    output logic [0:M-1]  a_vld,
    output word_t         b_in [0:K-1],
    output logic [0:K-1]  b_vld,
    output logic          busy,
    output logic          done_dispatch
);

    localparam int MN      = M * N;
    localparam int NK      = N * K;
    localparam int BUF_MAX = (MN > NK) ? MN : NK;
    localparam int MK_MAX  = (M > K) ? M : K;
    localparam int T       = N + MK_MAX - 1;
    localparam int PW      = $clog2(BUF_MAX) + 1;
    localparam int TW      = $clog2(T) + 1;
    localparam int AW      = (MN > 1) ? $clog2(MN) : 1;
    localparam int BBW     = (NK > 1) ? $clog2(NK) : 1;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_STEP = PW'(BW);
    localparam logic [PW-1:0] A_LAST   = PW'(MN - BW);
    localparam logic [PW-1:0] B_LAST   = PW'(NK - BW);
    localparam logic [TW-1:0] T_ZERO   = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] T_LAST   = TW'(T - 1);
    localparam word_t         WORD_ZERO = {WORD_W{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] t_q, t_d;
    logic          pop_s;

    word_t a_buf_q [0:MN-1];
    word_t b_buf_q [0:NK-1];

    // A is always row-major: the incoming flat position is the buffer index.
    function automatic logic [AW-1:0] a_wr_idx(input logic [PW-1:0] p, input int w);
        return AW'(int'(p) + w);
    endfunction

    // The B buffer is always row-major (n*K + j) so the stream path never changes.
    function automatic logic [BBW-1:0] b_wr_idx(input logic [PW-1:0] p, input int w);
        int f;
        f = int'(p) + w;
`ifdef DISPATCH_BTRANS_EN
        return BBW'((f % N) * K + (f / N));
`else
        return BBW'(f);
`endif
    endfunction

    function automatic logic skew_hit(input logic [TW-1:0] t, input int lane);
        return (int'(t) >= lane) && ((int'(t) - lane) < N);
    endfunction

    function automatic logic [AW-1:0] a_rd_idx(input logic [TW-1:0] t, input int i);
        return AW'(i * N + (int'(t) - i));
    endfunction

    function automatic logic [BBW-1:0] b_rd_idx(input logic [TW-1:0] t, input int j);
        return BBW'((int'(t) - j) * K + j);
    endfunction

    assign in_fifo_if.pop = pop_s;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_ZERO;
            t_q     <= T_ZERO;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            t_q     <= t_d;
        end
    end

    // Operand buffers capture every popped FIFO entry; their contents need no reset.
    always_ff @(posedge clk) begin
        if (pop_s && (state_q == S_LOAD_A)) begin
            for (int w = 0; w < BW; w++) begin
                a_buf_q[a_wr_idx(ptr_q, w)] <= in_fifo_if.dat_out[w];
            end
        end else if (pop_s && (state_q == S_LOAD_B)) begin
            for (int w = 0; w < BW; w++) begin
                b_buf_q[b_wr_idx(ptr_q, w)] <= in_fifo_if.dat_out[w];
            end
        end
    end

    // Next-state logic; pop follows !empty while loading, so an empty FIFO simply stalls.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        t_d     = t_q;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    ptr_d   = PTR_ZERO;
                    t_d     = T_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD_A: begin
                if (!in_fifo_if.empty) begin
                    pop_s = 1'b1;
                    if (ptr_q == A_LAST) begin
                        ptr_d   = PTR_ZERO;
                        state_d = S_LOAD_B;
                    end else begin
                        ptr_d = ptr_q + PTR_STEP;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            S_LOAD_B: begin
                if (!in_fifo_if.empty) begin
                    pop_s = 1'b1;
                    if (ptr_q == B_LAST) begin
                        ptr_d   = PTR_ZERO;
                        t_d     = T_ZERO;
                        state_d = S_STREAM;
                    end else begin
                        ptr_d = ptr_q + PTR_STEP;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            S_STREAM: begin
                if (t_q == T_LAST) begin
                    t_d     = T_ZERO;
                    state_d = S_DONE;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = PTR_ZERO;
                t_d     = T_ZERO;
            end
        endcase
    end

    // Skewed edge operands: row i / column j enters at t = i / j; slots outside the
    // window never touch the buffers.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            a_in[i]  = WORD_ZERO;
            a_vld[i] = 1'b0;
        end
        for (int j = 0; j < K; j++) begin
            b_in[j]  = WORD_ZERO;
            b_vld[j] = 1'b0;
        end
        if (state_q == S_STREAM) begin
            for (int i = 0; i < M; i++) begin
                if (skew_hit(t_q, i)) begin
                    a_vld[i] = 1'b1;
                    a_in[i]  = a_buf_q[a_rd_idx(t_q, i)];
                end else begin
                    a_vld[i] = 1'b0;
                    a_in[i]  = WORD_ZERO;
                end
            end
            for (int j = 0; j < K; j++) begin
                if (skew_hit(t_q, j)) begin
                    b_vld[j] = 1'b1;
                    b_in[j]  = b_buf_q[b_rd_idx(t_q, j)];
                end else begin
                    b_vld[j] = 1'b0;
                    b_in[j]  = WORD_ZERO;
                end
            end
        end else begin
            a_vld = {M{1'b0}};
            b_vld = {K{1'b0}};
        end
    end

    // Status flags decode directly from the state register.
    always_comb begin
        busy          = 1'b0;
        done_dispatch = 1'b0;
        case (state_q)
            S_LOAD_A, S_LOAD_B, S_STREAM: busy = 1'b1;
            S_DONE:                       done_dispatch = 1'b1;
            S_IDLE:                       busy = 1'b0;
            default: begin
                busy          = 1'b0;
                done_dispatch = 1'b0;
            end
        endcase
    end

endmodule
